// File: rtl/tensor_cfg_arbiter_if.sv
// Bundle of requester-side and read-engine-side signals around the config arbiter.
// Purely structural: no state and no latency of its own.
// Flow control: valid/ready per requester; valid/ready plus a done pulse toward the read engine.
interface tensor_cfg_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ*54-1:0] req_tdata;
    logic [NUM_REQ-1:0]    req_tvalid;
    logic [NUM_REQ-1:0]    req_tready;
    logic [53:0]           cfg_out_tdata;
    logic                  cfg_out_tvalid;
    logic                  cfg_out_tready;
    logic                  rd_done;
    logic [NUM_REQ-1:0]    done_out;
    logic [1:0]            grant_id;
    logic                  busy;
    logic [7:0]            drop_count;
    logic                  timeout_err;

    // Arbiter side
    modport master (
        input  req_tdata, req_tvalid, cfg_out_tready, rd_done,
        output req_tready, cfg_out_tdata, cfg_out_tvalid, done_out,
               grant_id, busy, drop_count, timeout_err
    );

    // Environment side (requesters plus read engine)
    modport slave (
        output req_tdata, req_tvalid, cfg_out_tready, rd_done,
        input  req_tready, cfg_out_tdata, cfg_out_tvalid, done_out,
               grant_id, busy, drop_count, timeout_err
    );
endinterface

// File: rtl/tensor_cfg_arbiter.sv
// Round-robin arbiter forwarding one tensor descriptor at a time to the read engine, with drop and watchdog.
// Latency: accept in IDLE, descriptor valid the next cycle; done pulse one cycle after rd_done.
// Backpressure: holds the descriptor in ISSUE until cfg_out_tready; requesters see ready only in IDLE.
module tensor_cfg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clock,
    input  logic                reset,
    tensor_cfg_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [53:0]        desc_q;
    logic [NUM_REQ-1:0] done_q;
    logic [1:0]         grant_q;
    logic [1:0]         last_q;
    logic [7:0]         drop_q;
    logic               terr_q;
    logic [15:0]        wdog_q;

    logic [1:0]         win;
    logic               any_vld;
    logic [2:0]         cand;
    logic [53:0]        win_desc;
    logic               zero_len;
    logic               accept;
    logic               wdog_hit;

    logic [NUM_REQ-1:0] rdy_c;
    logic               cfg_vld_c;
    logic               busy_c;

    // Round-robin search starting just after the last winner, wrapping at NUM_REQ
    always_comb begin
        win     = '0;
        any_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = 3'(last_q) + 3'(i) + 3'd1;
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!any_vld && bus.req_tvalid[cand[1:0]]) begin
                any_vld = 1'b1;
                win     = cand[1:0];
            end
        end
    end

    assign win_desc = bus.req_tdata[54*int'(win) +: 54];
    // size_code sits at [42:40], count at [39:0]
    assign zero_len = (win_desc[42:40] == 3'd0) || (win_desc[39:0] == 40'd0);
    // No acceptance while reset is high, so the requester never sees a phantom handshake
    assign accept   = (state == IDLE) && any_vld && !reset;
    assign wdog_hit = (wdog_q == 16'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: zero-length descriptors stay in IDLE; rd_done wins over watchdog expiry
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && !zero_len)     state_nxt = ISSUE;
            ISSUE:   if (bus.cfg_out_tready)      state_nxt = WAIT;
            WAIT:    if (bus.rd_done || wdog_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; cfg valid is purely a function of state
    always_comb begin
        rdy_c     = '0;
        if (accept) begin
            rdy_c[win] = 1'b1;
        end
        cfg_vld_c = (state == ISSUE);
        busy_c    = (state != IDLE);
    end

    // Descriptor latch, grant tracking, completion pulses, drop counter and watchdog
    always_ff @(posedge clock) begin
        if (reset) begin
            desc_q  <= '0;
            done_q  <= '0;
            grant_q <= '0;
            last_q  <= 2'(NUM_REQ - 1);
            drop_q  <= '0;
            terr_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            done_q <= '0;

            if (accept) begin
                desc_q  <= win_desc;
                grant_q <= win;
                last_q  <= win;
                if (zero_len) begin
                    done_q[win] <= 1'b1;
                    if (drop_q != 8'hFF) begin
                        drop_q <= drop_q + 8'd1;
                    end
                end
            end

            if (state == ISSUE && bus.cfg_out_tready) begin
                wdog_q <= '0;
            end else if (state == WAIT) begin
                wdog_q <= wdog_q + 16'd1;
            end

            if (state == WAIT) begin
                if (bus.rd_done) begin
                    done_q[grant_q] <= 1'b1;
                end else if (wdog_hit) begin
                    terr_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req_tready     = rdy_c;
    assign bus.cfg_out_tvalid = cfg_vld_c;
    assign bus.cfg_out_tdata  = desc_q;
    assign bus.done_out       = done_q;
    assign bus.grant_id       = grant_q;
    assign bus.busy           = busy_c;
    assign bus.drop_count     = drop_q;
    assign bus.timeout_err    = terr_q;

endmodule

// File: tb/tb_tensor_cfg_arbiter.sv
// Directed bench for tensor_cfg_arbiter: round-robin order, ISSUE hold, drop, watchdog, reset abort.
// Inputs change 2 time units after the rising edge; outputs are sampled between edges.
// All waits are fixed-length cycle counts, so the run always terminates.
module tb_tensor_cfg_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tensor_cfg_arbiter_if #(.NUM_REQ(4)) bus ();

    tensor_cfg_arbiter #(
        .NUM_REQ (4),
        .TIMEOUT (16)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [53:0] d [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [53:0] mk(input logic [10:0] b, input logic [2:0] s, input logic [39:0] c);
        return {b, s, c};
    endfunction

    task automatic pack();
        for (int i = 0; i < 4; i++) begin
            bus.req_tdata[54*i +: 54] = d[i];
        end
    endtask

    initial begin
        bus.req_tdata      = '0;
        bus.req_tvalid     = '0;
        bus.cfg_out_tready = 1'b0;
        bus.rd_done        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d[i] = mk(11'(i + 1), 3'd1, 40'(100 + i));
        end
        pack();

        // Reset values
        step();
        step();
        chk("rst_busy",   bus.busy, 0);
        chk("rst_tvalid", bus.cfg_out_tvalid, 0);
        chk("rst_tdata",  bus.cfg_out_tdata, 0);
        chk("rst_done",   bus.done_out, 0);
        chk("rst_grant",  bus.grant_id, 0);
        chk("rst_drop",   bus.drop_count, 0);
        chk("rst_terr",   bus.timeout_err, 0);
        rst = 1'b0;

        // Round robin with all requesters valid: 0,1,2,3,0
        bus.req_tvalid     = 4'hF;
        bus.cfg_out_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            #1;
            chk("rr_ready", bus.req_tready, 64'(1) << e);
            step();
            chk("rr_grant",       bus.grant_id, e);
            chk("rr_tvalid",      bus.cfg_out_tvalid, 1);
            chk("rr_tdata",       bus.cfg_out_tdata, d[e]);
            chk("rr_ready_issue", bus.req_tready, 0);
            step();
            chk("rr_wait_tvalid", bus.cfg_out_tvalid, 0);
            bus.rd_done = 1'b1;
            step();
            bus.rd_done = 1'b0;
            chk("rr_done", bus.done_out, 64'(1) << e);
        end
        bus.req_tvalid = '0;
        step();
        chk("rr_done_clear", bus.done_out, 0);
        chk("rr_idle",       bus.busy, 0);

        // Requester 2 held in ISSUE for 5 cycles of no ready
        d[2] = mk(11'h10, 3'd3, 40'd8);
        pack();
        bus.cfg_out_tready = 1'b0;
        bus.req_tvalid     = 4'b0100;
        #1;
        chk("hold_ready", bus.req_tready, 4'b0100);
        step();
        bus.req_tvalid = '0;
        for (int c = 0; c < 6; c++) begin
            chk("hold_tvalid", bus.cfg_out_tvalid, 1);
            chk("hold_tdata",  bus.cfg_out_tdata, d[2]);
            if (c == 5) bus.cfg_out_tready = 1'b1;
            step();
        end
        chk("hold_wait_busy",   bus.busy, 1);
        chk("hold_wait_tvalid", bus.cfg_out_tvalid, 0);
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        chk("hold_done", bus.done_out, 4'b0100);

        // Requester 1 with count=0 is dropped
        d[1] = mk(11'd5, 3'd2, 40'd0);
        pack();
        bus.req_tvalid = 4'b0010;
        #1;
        chk("drop_ready", bus.req_tready, 4'b0010);
        step();
        bus.req_tvalid = '0;
        #1;
        chk("drop_done",   bus.done_out, 4'b0010);
        chk("drop_count",  bus.drop_count, 1);
        chk("drop_busy",   bus.busy, 0);
        chk("drop_tvalid", bus.cfg_out_tvalid, 0);
        chk("drop_ready0", bus.req_tready, 0);
        chk("drop_grant",  bus.grant_id, 1);

        // Stale rd_done in IDLE, then watchdog abort for requester 3
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        chk("stale_done", bus.done_out, 0);
        chk("stale_busy", bus.busy, 0);
        bus.req_tvalid = 4'b1000;
        #1;
        chk("wd_ready", bus.req_tready, 4'b1000);
        step();
        bus.req_tvalid = '0;
        chk("wd_issue_busy", bus.busy, 1);
        step();
        repeat (15) step();
        chk("wd_still_wait", bus.busy, 1);
        chk("wd_terr_pre",   bus.timeout_err, 0);
        step();
        chk("wd_terr",  bus.timeout_err, 1);
        chk("wd_done",  bus.done_out, 0);
        chk("wd_idle",  bus.busy, 0);

        // Normal grant after timeout
        bus.req_tvalid = 4'b0001;
        #1;
        chk("post_wd_ready", bus.req_tready, 4'b0001);
        step();
        bus.req_tvalid = '0;
        chk("post_wd_grant", bus.grant_id, 0);
        chk("post_wd_busy",  bus.busy, 1);
        step();
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        chk("post_wd_done", bus.done_out, 4'b0001);
        chk("post_wd_terr", bus.timeout_err, 1);

        // Reset during WAIT for requester 3
        bus.req_tvalid = 4'b1000;
        #1;
        chk("rstw_ready", bus.req_tready, 4'b1000);
        step();
        bus.req_tvalid = '0;
        step();
        chk("rstw_grant", bus.grant_id, 3);
        rst = 1'b1;
        bus.req_tvalid = 4'hF;
        #1;
        chk("rstw_ready_in_rst", bus.req_tready, 0);
        step();
        rst = 1'b0;
        chk("rstw_busy",  bus.busy, 0);
        chk("rstw_done",  bus.done_out, 0);
        chk("rstw_terr",  bus.timeout_err, 0);
        #1;
        chk("rstw_next_ready", bus.req_tready, 4'b0001);
        step();
        bus.req_tvalid = '0;
        chk("rstw_next_grant", bus.grant_id, 0);
        chk("rstw_no_done",    bus.done_out, 0);

        // rd_done on the same cycle the watchdog expires: completion wins
        step();
        repeat (15) step();
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
        chk("tie_done", bus.done_out, 4'b0001);
        chk("tie_terr", bus.timeout_err, 0);
        chk("tie_idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
